uart_icb_master: RTL and testbench

UART_ICB_MASTER -- requirements
Module: uart_icb_master

---
 rtl/uart_icb_master_pkg.sv | 27 ++
 rtl/uart_icb_master_fifo.sv | 58 +++++
 rtl/uart_icb_master.sv | 190 +++++++++++++++++++
 tb/tb_uart_icb_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_icb_master_pkg.sv
// Shared definitions for the UART ICB master: bus width, register map,
// CSR status bit position and FSM state encodings.
package uart_icb_master_pkg;

  localparam int PA_SIZE = 32;

  // UART register map as seen from the ICB initiator
  localparam logic [PA_SIZE-1:0] DATA_REG_ADDR = 32'h1001_3000;
  localparam logic [PA_SIZE-1:0] UART_CSR_ADDR = 32'h1001_3004;

  // CSR bit that reports the transmitter can accept another byte
  localparam int CSR_TX_OK_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_POLL_CMD = 3'd1,
    ST_POLL_RSP = 3'd2,
    ST_WR_CMD   = 3'd3,
    ST_WR_RSP   = 3'd4
  } state_t;

  // Zero-extend a byte onto the ICB write-data bus
  function automatic logic [PA_SIZE-1:0] byte_to_wdata(input logic [7:0] b);
    return {{(PA_SIZE-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_icb_master_fifo.sv
// uart_byte_fifo: small synchronous byte FIFO with first-word-fall-through
// head output. FIFO_DEPTH must be a power of two so the pointers wrap freely.
module uart_byte_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Over/underflow protection: ignore pushes when full and pops when empty
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Byte storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keeps count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_icb_master.sv
// uart_icb_master: ICB initiator that drains a byte FIFO into the UART data
// register, one transaction at a time. Optional CSR tx_ok polling before each
// byte is enabled by defining the macro UART_TX_POLL_EN; without it each byte
// is written straight away and timeout_err is tied low.
module uart_icb_master
  import uart_icb_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_LIMIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  output logic               o_icb_cmd_valid,
  input  logic               o_icb_cmd_ready,
  output logic [PA_SIZE-1:0] o_icb_cmd_addr,
  output logic               o_icb_cmd_read,
  output logic [PA_SIZE-1:0] o_icb_cmd_wdata,
  input  logic               o_icb_rsp_valid,
  output logic               o_icb_rsp_ready,
  input  logic [PA_SIZE-1:0] o_icb_rsp_rdata,
  input  logic               err_clr,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        sent_cnt
);

  localparam logic [7:0] POLL_LIMIT_C = POLL_LIMIT[7:0];

  state_t     state;
  logic       rdy_en;
  logic       push;
  logic       pop;
  logic [7:0] head;
  logic       full;
  logic       empty;
  logic       unused_ok;

`ifdef UART_TX_POLL_EN
  logic [7:0] poll_cnt;
  logic       poll_last;
  logic       tx_ok;

  assign tx_ok     = o_icb_rsp_rdata[CSR_TX_OK_BIT];
  assign poll_last = ((poll_cnt + 8'd1) == POLL_LIMIT_C);
`endif

  // Inputs that only matter in some build configurations
  assign unused_ok = ^{o_icb_rsp_rdata, err_clr, POLL_LIMIT_C};

  // Input stream accepted only once out of reset and while space remains
  assign s_ready = rdy_en & ~full;
  assign push    = s_valid & s_ready;
  assign busy    = (state != ST_IDLE);

  // Hold s_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Head byte leaves the FIFO once written, or when polling gives up on it
  always_comb begin
    pop = 1'b0;
    if (state == ST_WR_RSP && o_icb_rsp_valid) pop = 1'b1;
`ifdef UART_TX_POLL_EN
    if (state == ST_POLL_RSP && o_icb_rsp_valid && !tx_ok && poll_last) pop = 1'b1;
`endif
  end

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

`ifndef UART_TX_POLL_EN
  assign timeout_err = 1'b0;
`endif

  // Transaction sequencer; all ICB outputs are registered and only change
  // on state transitions, so they stay stable while a command waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      o_icb_cmd_valid <= 1'b0;
      o_icb_cmd_read  <= 1'b0;
      o_icb_cmd_addr  <= '0;
      o_icb_cmd_wdata <= '0;
      o_icb_rsp_ready <= 1'b0;
      sent_cnt        <= '0;
`ifdef UART_TX_POLL_EN
      poll_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_POLL_EN
      // A timeout set later in this block overrides the clear
      if (err_clr) timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (!empty) begin
`ifdef UART_TX_POLL_EN
            state           <= ST_POLL_CMD;
            poll_cnt        <= '0;
            o_icb_cmd_valid <= 1'b1;
            o_icb_cmd_read  <= 1'b1;
            o_icb_cmd_addr  <= UART_CSR_ADDR;
            o_icb_cmd_wdata <= '0;
`else
            state           <= ST_WR_CMD;
            o_icb_cmd_valid <= 1'b1;
            o_icb_cmd_read  <= 1'b0;
            o_icb_cmd_addr  <= DATA_REG_ADDR;
            o_icb_cmd_wdata <= byte_to_wdata(head);
`endif
          end
        end

`ifdef UART_TX_POLL_EN
        ST_POLL_CMD: begin
          if (o_icb_cmd_ready) begin
            state           <= ST_POLL_RSP;
            o_icb_cmd_valid <= 1'b0;
            o_icb_rsp_ready <= 1'b1;
          end
        end

        ST_POLL_RSP: begin
          if (o_icb_rsp_valid) begin
            o_icb_rsp_ready <= 1'b0;
            if (tx_ok) begin
              state           <= ST_WR_CMD;
              o_icb_cmd_valid <= 1'b1;
              o_icb_cmd_read  <= 1'b0;
              o_icb_cmd_addr  <= DATA_REG_ADDR;
              o_icb_cmd_wdata <= byte_to_wdata(head);
            end else begin
              poll_cnt <= poll_cnt + 8'd1;
              if (poll_last) begin
                state       <= ST_IDLE;
                timeout_err <= 1'b1;
              end else begin
                state           <= ST_POLL_CMD;
                o_icb_cmd_valid <= 1'b1;
                o_icb_cmd_read  <= 1'b1;
                o_icb_cmd_addr  <= UART_CSR_ADDR;
                o_icb_cmd_wdata <= '0;
              end
            end
          end
        end
`endif

        ST_WR_CMD: begin
          if (o_icb_cmd_ready) begin
            state           <= ST_WR_RSP;
            o_icb_cmd_valid <= 1'b0;
            o_icb_rsp_ready <= 1'b1;
          end
        end

        ST_WR_RSP: begin
          if (o_icb_rsp_valid) begin
            state           <= ST_IDLE;
            o_icb_rsp_ready <= 1'b0;
            sent_cnt        <= sent_cnt + 16'd1;
          end
        end

        default: begin
          state           <= ST_IDLE;
          o_icb_cmd_valid <= 1'b0;
          o_icb_rsp_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_icb_master.sv
// Self-checking bench for uart_icb_master: an ICB slave responder, a byte
// queue reference model, a table of single-byte transactions, directed
// corner cases (timeout, back-pressure, full FIFO, reset) and random traffic.
`timescale 1ns/1ps
module tb_uart_icb_master;
  import uart_icb_master_pkg::*;

`ifdef UART_TX_POLL_EN
  localparam int P_LIMIT = 5;
  localparam bit POLL_ON = 1'b1;
`else
  localparam int P_LIMIT = 255;
  localparam bit POLL_ON = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] addr;
  logic        read;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rdata;
  logic        err_clr;
  logic        busy;
  logic        timeout_err;
  logic [15:0] sent_cnt;

  always #5 clk = ~clk;

  uart_icb_master #(
    .FIFO_DEPTH (DEPTH),
    .POLL_LIMIT (P_LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .o_icb_cmd_valid (cmd_valid),
    .o_icb_cmd_ready (cmd_ready),
    .o_icb_cmd_addr  (addr),
    .o_icb_cmd_read  (read),
    .o_icb_cmd_wdata (wdata),
    .o_icb_rsp_valid (rsp_valid),
    .o_icb_rsp_ready (rsp_ready),
    .o_icb_rsp_rdata (rdata),
    .err_clr         (err_clr),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .sent_cnt        (sent_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder controls and transaction log
  bit         rand_mode = 1'b0;
  bit         stall = 1'b0;
  bit         rsp_hold = 1'b0;
  bit         csr_always_zero = 1'b0;
  int         csr_zeros = 0;
  int         csr_plan = 0;
  int         hold_left = 0;
  bit         pend = 1'b0;
  bit         pend_read = 1'b0;
  bit         last_cmd_hs = 1'b0;
  bit         last_rsp_hs = 1'b0;
  bit         last_read = 1'b0;
  int         delay = 0;
  logic [7:0] write_log[$];
  int         poll_reads = 0;

  // Reference model: bytes still owed to the UART and the expected counter
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_sent = 16'd0;
  int          wr_idx = 0;

  function automatic logic [31:0] csr_word();
    logic [31:0] r;
    r = $urandom;
    if (csr_always_zero) return {r[31:1], 1'b0};
    if (csr_zeros > 0) begin
      csr_zeros--;
      return {r[31:1], 1'b0};
    end
    return {r[31:1], 1'b1};
  endfunction

  // ICB slave: decides cmd_ready / rsp_valid for the next edge and logs
  // every command that will be accepted on that edge
  initial begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rdata     = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        pend        = 1'b0;
        last_cmd_hs = 1'b0;
        last_rsp_hs = 1'b0;
      end else begin
        if (last_rsp_hs) begin
          if (!pend_read) csr_zeros = rand_mode ? $urandom_range(0, P_LIMIT - 2) : csr_plan;
          pend      = 1'b0;
          rsp_valid = 1'b0;
        end
        if (last_cmd_hs) begin
          pend      = 1'b1;
          pend_read = last_read;
          delay     = rand_mode ? $urandom_range(0, 2) : 0;
        end
        if (pend && !rsp_valid) begin
          if (delay > 0) delay--;
          else if (!(rsp_hold && !pend_read)) begin
            rsp_valid = 1'b1;
            rdata     = pend_read ? csr_word() : $urandom;
          end
        end
        if (pend) check("cmd_valid_while_pending", {31'd0, cmd_valid}, 32'd0);
        check("rsp_ready_phase", {31'd0, rsp_ready}, {31'd0, pend});

        if (stall) cmd_ready = 1'b0;
        else if (hold_left > 0 && cmd_valid && !read) begin
          cmd_ready = 1'b0;
          hold_left--;
        end else cmd_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

        last_cmd_hs = cmd_valid && cmd_ready;
        last_read   = read;
        if (last_cmd_hs) begin
          if (read) begin
            poll_reads++;
            check("csr_read_addr", addr, UART_CSR_ADDR);
            check("csr_read_wdata", wdata, 32'd0);
          end else begin
            write_log.push_back(wdata[7:0]);
            check("data_write_addr", addr, DATA_REG_ADDR);
            check("data_write_upper", {8'd0, wdata[31:8]}, 32'd0);
          end
        end
        last_rsp_hs = rsp_valid && rsp_ready;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!s_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      check("push_wait_s_ready", {31'd0, s_ready}, 32'd1);
      return;
    end
    s_valid = 1'b1;
    s_data  = b;
    exp_bytes.push_back(b);
    exp_sent = exp_sent + 16'd1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Wait until the block has been idle for several consecutive cycles
  task automatic settle(input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 3) check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_writes(input string tag);
    int got;
    got = write_log.size() - wr_idx;
    check({tag, "_write_count"}, got, exp_bytes.size());
    while (wr_idx < write_log.size() && exp_bytes.size() > 0) begin
      check({tag, "_write_data"}, {24'd0, write_log[wr_idx]}, {24'd0, exp_bytes.pop_front()});
      wr_idx++;
    end
    wr_idx = write_log.size();
    exp_bytes.delete();
    check({tag, "_sent_cnt"}, {16'd0, sent_cnt}, {16'd0, exp_sent});
  endtask

  task automatic wait_cmd(input string tag, input bit want_write);
    int n;
    n = 0;
    while (!(cmd_valid && (!want_write || !read)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_reach_cmd"}, {31'd0, cmd_valid}, 32'd1);
  endtask

  // Async reset pulse mid-cycle, immediate output checks, then release
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_cmd_valid_async"}, {31'd0, cmd_valid}, 32'd0);
    check({tag, "_busy_async"}, {31'd0, busy}, 32'd0);
    check({tag, "_rsp_ready_async"}, {31'd0, rsp_ready}, 32'd0);
    check({tag, "_s_ready_async"}, {31'd0, s_ready}, 32'd0);
    wr_idx = write_log.size();
    exp_bytes.delete();
    exp_sent = 16'd0;
    @(posedge clk); #1;
    rst      = 1'b0;
    stall    = 1'b0;
    rsp_hold = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_s_ready_after"}, {31'd0, s_ready}, 32'd1);
    check_writes({tag, "_after"});
  endtask

  typedef struct {
    logic [7:0] data;
    int         zeros;
    int         polls;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int p0;
    int n;
    logic [31:0] ca;
    logic [31:0] cw;
    logic        cr;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'd0;
    err_clr = 1'b0;

    vecs[0] = '{data: 8'h5A, zeros: 0, polls: 0};
    vecs[1] = '{data: 8'hA5, zeros: 3, polls: 0};
    vecs[2] = '{data: 8'h00, zeros: 1, polls: 0};
    vecs[3] = '{data: 8'hFF, zeros: 2, polls: 0};
    for (int i = 0; i < 4; i++) vecs[i].polls = POLL_ON ? vecs[i].zeros + 1 : 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_rsp_ready", {31'd0, rsp_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_sent_cnt", {16'd0, sent_cnt}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_read", {31'd0, read}, 32'd0);

    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_first_edge", {31'd0, s_ready}, 32'd1);

    // Table of single-byte transactions
    for (int i = 0; i < 4; i++) begin
      p0 = poll_reads;
      csr_zeros = vecs[i].zeros;
      csr_plan  = vecs[i].zeros;
      push_byte(vecs[i].data);
      check("latency_push_edge", {31'd0, cmd_valid}, 32'd0);
      @(posedge clk); #1;
      check("latency_cmd_valid", {31'd0, cmd_valid}, 32'd1);
      check("busy_active", {31'd0, busy}, 32'd1);
      settle("vec");
      check("vec_poll_reads", poll_reads - p0, vecs[i].polls);
      check_writes("vec");
      check("vec_busy_idle", {31'd0, busy}, 32'd0);
    end
    csr_plan  = 0;
    csr_zeros = 0;

    // Poll timeout drops the byte (or, without polling, the flag stays low)
    p0 = poll_reads;
    csr_always_zero = 1'b1;
`ifdef UART_TX_POLL_EN
    push_byte(8'h33);
    void'(exp_bytes.pop_back());
    exp_sent = exp_sent - 16'd1;
    settle("timeout");
    check("timeout_polls", poll_reads - p0, P_LIMIT);
    check("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    check_writes("timeout");
    csr_always_zero = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("timeout_err_clr", {31'd0, timeout_err}, 32'd0);
`else
    push_byte(8'h33);
    settle("nopoll");
    check("nopoll_polls", poll_reads - p0, 0);
    check("timeout_err_tied", {31'd0, timeout_err}, 32'd0);
    check_writes("nopoll");
    csr_always_zero = 1'b0;
`endif

    // Back-pressure on the data write: command fields must hold
    hold_left = 5;
    push_byte(8'h3C);
    wait_cmd("hold", 1'b1);
    ca = addr;
    cw = wdata;
    cr = read;
    check("hold_wdata_value", cw, 32'h0000_003C);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, cmd_valid}, 32'd1);
      check("hold_addr", addr, ca);
      check("hold_wdata", wdata, cw);
      check("hold_read", {31'd0, read}, {31'd0, cr});
    end
    settle("hold");
    check_writes("hold");

    // Fill the FIFO while the bus is stalled; extra pushes are refused
    stall = 1'b1;
    for (int k = 0; k < DEPTH; k++) push_byte(8'(8'h10 + k));
    check("full_s_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    check("full_s_ready_held", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b0;
    stall   = 1'b0;
    settle("full");
    check_writes("full");

    // Reset while a command is being offered
    stall = 1'b1;
    push_byte(8'h71);
    wait_cmd("rst_cmd", 1'b0);
    mid_reset("rst_cmd");

    // Reset while waiting for the write response with bytes queued
    rsp_hold = 1'b1;
    for (int k = 0; k < 3; k++) push_byte(8'(8'h61 + k));
    n = 0;
    while (!(pend && !pend_read) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_rsp_reach_wr_rsp", {31'd0, pend && !pend_read}, 32'd1);
    check("rst_rsp_busy", {31'd0, busy}, 32'd1);
    check("rst_rsp_inflight", {24'd0, write_log[write_log.size() - 1]}, 32'h61);
    mid_reset("rst_rsp");

    // Random traffic against the byte-queue model
    rand_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      push_byte(8'($urandom));
    end
    settle("rand");
    check_writes("rand");
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
